rca_16bit: RTL and testbench
============================

// Module: rca_16bit
// PURPOSE
//   16-bit ripple-carry adder with carry-in, carry-out and two's-complement
//   overflow flag; results registered. Generic datapath arithmetic primitive
//   for ALU/accumulator paths needing both unsigned (cout) and signed (overflow) status.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; overflow defined on bit WIDTH-1
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   rst_n     in   1      synchronous active-low reset, sampled on rising clk
//   a         in   WIDTH  operand A (unsigned or two's complement)
//   b         in   WIDTH  operand B
//   cin       in   1      carry-in into bit 0
//   sum       out  WIDTH  registered (a + b + cin) mod 2^WIDTH
//   cout      out  1      registered carry out of bit WIDTH-1
//   overflow  out  1      registered signed overflow = c[WIDTH-1] ^ c[WIDTH]
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low.
//   - Rising clk with rst_n=0: sum=0, cout=0, overflow=0. Reset wins over any input.
//   - Rising clk with rst_n=1: capture a, b, cin; combinational result appears on
//     outputs after that edge. Latency 1 cycle, throughput 1 op/cycle, no handshake.
//   - Carry chain: c[0]=cin; for i in 0..WIDTH-1: s[i]=a^b^c[i],
//     c[i+1]=(a&b)|(a&c[i])|(b&c[i]); cout=c[WIDTH].
//   - overflow=1 iff the signed sum of a, b and cin is outside the signed WIDTH-bit
//     range. Equals XOR of the carry into and the carry out of the MSB.
//   - Boundaries: full-scale sum 0xFFFF+0xFFFF+1=0x1FFFF gives sum=0xFFFF, cout=1.
//     Wrap to zero gives sum=0 with cout=1.
//   - Inputs changing between edges have no effect on outputs until the next edge.
//   - No X propagation from reset state: outputs are defined from the first reset edge.
// STRUCTURE
//   - Sub-module full_adder: 1-bit, ports a, b, ci, s, co.
//     Instantiate WIDTH times with a generate loop; carry wire vector c[WIDTH:0].
//   - Output register stage lives in rca_16bit itself.
//   - Shared package: none needed. WIDTH stays a local parameter of the module.
// TESTING
//   1. rst_n=0 for 2 cycles with a=b=0xFFFF, cin=1 -> sum=0, cout=0, overflow=0.
//   2. a=9, b=5, cin=1 -> next cycle sum=15, cout=0, overflow=0.
//      a=17, b=56, cin=0 -> sum=73.
//      a=556, b=965, cin=1 -> sum=1522, cout=0, overflow=0.
//   3. a=49152, b=49152, cin=1 -> sum=32769 (0x8001), cout=1, overflow=0.
//   4. a=32767, b=32768, cin=1 -> sum=0, cout=1, overflow=0.
//   5. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1.
//      a=0x8000, b=0x8000, cin=0 -> sum=0, cout=1, overflow=1.
//   6. Back-to-back vectors every cycle with rst_n dropped mid-stream:
//      - each result appears exactly 1 cycle after its inputs;
//      - the cycle after rst_n=0, outputs are 0;
//      - compare against a reference {cout,sum}=a+b+cin over 10k random vectors.

Source files
------------

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell used to build the ripple chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/rca_16bit.sv
// rca_16bit: registered ripple-carry adder with carry-out and signed overflow
module rca_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;
    assign w_c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(w_c[i]),
            .s (w_s[i]),
            .co(w_c[i+1])
        );
    end
    // signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_sum      <= w_s;
            r_cout     <= w_c[WIDTH];
            r_overflow <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
    end
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_rca_16bit.sv
// tb_rca_16bit: directed and randomized checks of rca_16bit against an arithmetic model
module tb_rca_16bit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout, overflow;
    int          tests = 0;
    int          fails = 0;

    rca_16bit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // returns {cout, overflow, sum} from plain integer arithmetic
    function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y, input logic c);
        int u, s;
        logic ov;
        logic [16:0] u17;
        u   = int'(x) + int'(y) + int'(c);
        s   = int'($signed(x)) + int'($signed(y)) + int'(c);
        ov  = (s > 32767) || (s < -32768);
        u17 = u[16:0];
        return {u17[16], ov, u17[15:0]};
    endfunction

    task automatic drive(input logic rn, input logic [15:0] x, input logic [15:0] y, input logic c);
        rst_n = rn; a = x; b = y; cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
            tests++;
            if ({cout, overflow, sum} !== 18'h0) begin
                fails++;
                $display("FAIL reset[%0d]: got cout=%b ov=%b sum=%h, want 0 0 0000", i, cout, overflow, sum);
            end
        end
    endtask

    task automatic test_directed;
        logic [15:0] va [8] = '{16'd9, 16'd17, 16'd556, 16'd49152, 16'd32767, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [15:0] vb [8] = '{16'd5, 16'd56, 16'd965, 16'd49152, 16'd32768, 16'h0001, 16'h8000, 16'hFFFF};
        logic        vc [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] es [8] = '{16'd15, 16'd73, 16'd1522, 16'h8001, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF};
        logic        ec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        eo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            tests++;
            if ({cout, overflow, sum} !== {ec[i], eo[i], es[i]}) begin
                fails++;
                $display("FAIL directed[%0d] %h+%h+%b: got cout=%b ov=%b sum=%h, want %b %b %h",
                         i, va[i], vb[i], vc[i], cout, overflow, sum, ec[i], eo[i], es[i]);
            end
        end
    endtask

    task automatic test_hold;
        logic [17:0] exp;
        for (int i = 0; i < 20; i++) begin
            logic [15:0] x, y;
            logic        c;
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            exp = ref_model(x, y, c);
            drive(1'b1, x, y, c);
            #1;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); rst_n = 1'($urandom);
            #2;
            tests++;
            if ({cout, overflow, sum} !== exp) begin
                fails++;
                $display("FAIL hold[%0d]: got %h, want %h", i, {cout, overflow, sum}, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] exp;
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] x, y;
            logic        c, rn;
            x  = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            rn = ((i % 1000) == 500) ? 1'b0 : ($urandom_range(0, 99) != 0);
            exp = rn ? ref_model(x, y, c) : 18'h0;
            drive(rn, x, y, c);
            tests++;
            if ({cout, overflow, sum} !== exp) begin
                fails++;
                $display("FAIL b2b[%0d] rst_n=%b %h+%h+%b: got cout=%b ov=%b sum=%h, want %h",
                         i, rn, x, y, c, cout, overflow, sum, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset;
        test_directed;
        test_hold;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
